// File: rtl/myproject_mac_pkg.sv
// myproject_mac_pkg
// Shared helpers for the pipelined multiply-accumulate unit:
//   - prod_width : bit width of the full din0 x din1 product
//   - sat_max/min: signed clip limits for a given result width
//   - params_ok  : legality of the stage count and accumulator width
// No ports (package).
package myproject_mac_pkg;

  // An unsigned weight gains a zero sign bit before the multiply, so the
  // product needs one extra bit in that case.
  function automatic int prod_width(input int din0_w, input int din1_w,
                                    input int din1_signed);
    return din0_w + din1_w + ((din1_signed != 0) ? 0 : 1);
  endfunction

  function automatic longint sat_max(input int dout_w);
    return (longint'(1) << (dout_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int dout_w);
    return -(longint'(1) << (dout_w - 1));
  endfunction

  function automatic bit params_ok(input int num_stage, input int acc_w,
                                   input int din0_w, input int din1_w);
    return (num_stage >= 1) && (num_stage <= 4) &&
           (acc_w >= din0_w + din1_w + 1);
  endfunction

endpackage

// File: rtl/myproject_mac_mul_pipe.sv
// myproject_mac_mul_pipe
// Operand extension, signed multiply and NUM_STAGE enable-gated registers
// carrying the product (sign-extended to ACC_WIDTH), its valid bit and the
// group-end tag.
// Ports:
//   ap_clk, ap_rst_n    clock / async active-low reset
//   en                  global pipeline enable (hold everything when 0)
//   in_valid, in_last   beat qualifier and group-end tag
//   din0, din1          activation (signed) and weight operands
//   prod_out            final-stage product, ACC_WIDTH signed
//   valid_out, last_out final-stage valid and last tag
module myproject_mac_mul_pipe
  import myproject_mac_pkg::*;
#(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 12,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 40
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic [ACC_WIDTH-1:0]  prod_out,
  output logic                  valid_out,
  output logic                  last_out
);

  localparam int PROD_W = prod_width(DIN0_WIDTH, DIN1_WIDTH, DIN1_SIGNED);
  localparam int D1X_W  = PROD_W - DIN0_WIDTH;

  logic [D1X_W-1:0]         din1_ext;
  logic signed [PROD_W-1:0] mul_full;
  logic [ACC_WIDTH-1:0]     mul_ext;

  logic [ACC_WIDTH-1:0] stage_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0] stage_valid;
  logic [NUM_STAGE-1:0] stage_last;

  // An unsigned weight is given a zero top bit so the signed multiply
  // treats it as non-negative.
  generate
    if (DIN1_SIGNED != 0) begin : g_din1_signed
      assign din1_ext = din1;
    end else begin : g_din1_unsigned
      assign din1_ext = {1'b0, din1};
    end
  endgenerate

  // Both operands are sign-extended to the product width before
  // multiplying, then the product is sign-extended to the accumulator.
  always_comb begin
    mul_full = PROD_W'($signed(din0)) * PROD_W'($signed(din1_ext));
    mul_ext  = ACC_WIDTH'(mul_full);
  end

  // Shift register of products with their valid/last tags; the whole chain
  // freezes when the downstream output register cannot take a result.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        stage_prod[i] <= '0;
      end
      stage_valid <= '0;
      stage_last  <= '0;
    end else if (en) begin
      stage_prod[0]  <= mul_ext;
      stage_valid[0] <= in_valid;
      stage_last[0]  <= in_valid && in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        stage_prod[i]  <= stage_prod[i-1];
        stage_valid[i] <= stage_valid[i-1];
        stage_last[i]  <= stage_last[i-1];
      end
    end
  end

  assign prod_out  = stage_prod[NUM_STAGE-1];
  assign valid_out = stage_valid[NUM_STAGE-1];
  assign last_out  = stage_last[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe
// Pipelined signed x (signed|unsigned) multiply-accumulate with group
// accumulation delimited by in_last, arithmetic right shift, saturation
// and valid/ready handshakes on both sides.
// Optional build macro MYPROJECT_MAC_ROUND_EN: round-half-up before the
// shift (default build truncates toward minus infinity).
// Ports:
//   ap_clk, ap_rst_n      clock / async active-low reset
//   in_valid, in_ready    operand beat handshake
//   din0, din1, in_last   operands and group-end marker
//   out_valid, out_ready  result handshake
//   dout, out_sat         saturated result and clip flag
module myproject_mac_pipe
  import myproject_mac_pkg::*;
#(
  parameter int DIN0_WIDTH  = 16,
  parameter int DIN1_WIDTH  = 12,
  parameter int DIN1_SIGNED = 0,
  parameter int NUM_STAGE   = 2,
  parameter int ACC_WIDTH   = 40,
  parameter int SHIFT       = 10,
  parameter int DOUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  out_sat
);

  generate
    if (!params_ok(NUM_STAGE, ACC_WIDTH, DIN0_WIDTH, DIN1_WIDTH)) begin : g_bad_params
      $error("myproject_mac_pipe: NUM_STAGE must be 1..4 and ACC_WIDTH >= DIN0_WIDTH+DIN1_WIDTH+1");
    end
  endgenerate

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(DOUT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(DOUT_WIDTH));
`ifdef MYPROJECT_MAC_ROUND_EN
  localparam logic signed [ACC_WIDTH-1:0] ROUND_TERM = (SHIFT > 0) ?
    ACC_WIDTH'(longint'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`endif

  logic                        en;
  logic [ACC_WIDTH-1:0]        mul_prod;
  logic                        mul_valid;
  logic                        mul_last;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] rounded;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic                        clip_hi;
  logic                        clip_lo;
  logic [DOUT_WIDTH-1:0]       clipped;

  // The whole design advances only when the output register is free or
  // being emptied this cycle; the input side sees the same enable.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  myproject_mac_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DIN1_SIGNED(DIN1_SIGNED),
    .NUM_STAGE  (NUM_STAGE),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mul (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_last  (in_last),
    .din0     (din0),
    .din1     (din1),
    .prod_out (mul_prod),
    .valid_out(mul_valid),
    .last_out (mul_last)
  );

  // Running sum, optional rounding bias, fixed-point rescale and clip.
  // All arithmetic wraps at ACC_WIDTH bits.
  always_comb begin
    sum = acc + $signed(mul_prod);
`ifdef MYPROJECT_MAC_ROUND_EN
    rounded = sum + ROUND_TERM;
`else
    rounded = sum;
`endif
    shifted = rounded >>> SHIFT;
    clip_hi = shifted > SAT_MAX;
    clip_lo = shifted < SAT_MIN;
    if (clip_hi) begin
      clipped = SAT_MAX[DOUT_WIDTH-1:0];
    end else if (clip_lo) begin
      clipped = SAT_MIN[DOUT_WIDTH-1:0];
    end else begin
      clipped = shifted[DOUT_WIDTH-1:0];
    end
  end

  // Accumulator: add non-last beats, clear on the last beat so the next
  // group starts from zero. Bubbles leave it untouched.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc <= '0;
    end else if (en && mul_valid) begin
      acc <= mul_last ? '0 : sum;
    end
  end

  // Output register: loads on a group end, otherwise drops valid once the
  // held result has been taken. dout/out_sat hold while unconsumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      if (mul_valid && mul_last) begin
        out_valid <= 1'b1;
        dout      <= clipped;
        out_sat   <= clip_hi || clip_lo;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
